// File: rtl/pipe_pkg.sv
// Shared types for the MiniMIPS32 elastic stage registers: the occupancy
// state machine encoding, the packed stage bundle and the NOP bundle used
// to fill bubbles.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    // The state encoding doubles as the occupancy count (entries held).
    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam logic [7:0] ALUOP_SLL = 8'h11;
    localparam logic [4:0] REG_NOP   = 5'd0;
    localparam logic [4:0] EXC_NONE  = 5'h10;

    // Bundle carried between EXE/MEM and MEM/WB.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  exccode;
        logic [7:0]  aluop;
        logic [4:0]  wa;
        logic        wreg;
        logic [31:0] wd;
        logic        mreg;
        logic [31:0] din;
        logic        cp0We;
        logic [4:0]  cp0Addr;
        logic [31:0] cp0Wd;
        logic        inDelay;
        logic [4:0]  rsvd;
    } stage_bundle_t;

    localparam int unsigned STAGE_BUNDLE_W = $bits(stage_bundle_t);

    // A bundle that retires as SLL $0,$0,0 with no exception and no writes.
    localparam stage_bundle_t NOP_BUNDLE = '{
        pc:      32'd0,
        exccode: EXC_NONE,
        aluop:   ALUOP_SLL,
        wa:      REG_NOP,
        wreg:    1'b0,
        wd:      32'd0,
        mreg:    1'b0,
        din:     32'd0,
        cp0We:   1'b0,
        cp0Addr: 5'd0,
        cp0Wd:   32'd0,
        inDelay: 1'b0,
        rsvd:    5'd0
    };

    // Occupancy count that corresponds to a given state.
    function automatic logic [OCC_W-1:0] occ_of_state(input stage_state_t st);
        return OCC_W'(st);
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake for one elastic stage: upstream push side and
// downstream pop side.  The stage itself uses the slave view.
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = STAGE_BUNDLE_W
) ();

    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic              dn_valid;
    logic              dn_ready;
    logic [DATA_W-1:0] dn_data;

    modport master (
        output up_valid,
        output up_data,
        output dn_ready,
        input  up_ready,
        input  dn_valid,
        input  dn_data
    );

    modport slave (
        input  up_valid,
        input  up_data,
        input  dn_ready,
        output up_ready,
        output dn_valid,
        output dn_data
    );

endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage register with an optional two-entry
// skid buffer.  With SKID=1 up_ready comes straight from a flop so a
// downstream stall never forms a combinational path back upstream.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = STAGE_BUNDLE_W,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter int unsigned       SKID        = 1
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic             flush,
    pipe_stage_buf_if.slave  bus,
    output logic [OCC_W-1:0] occupancy
);

    stage_state_t      r_state;
    stage_state_t      w_nextState;
    logic              r_dnValid;
    logic              r_upReady;
    logic [OCC_W-1:0]  r_occupancy;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_skidData;

    logic w_upReady;
    logic w_push;
    logic w_pop;
    logic w_loadMainUp;
    logic w_loadMainSkid;
    logic w_loadSkid;

    assign w_push = bus.up_valid & w_upReady;
    assign w_pop  = r_dnValid & bus.dn_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] r_skid;

            // Skid entry captures the second bundle when downstream stalls.
            always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
                if (!cpu_rst_n) begin
                    r_skid <= BUBBLE_DATA;
                end else if (w_loadSkid) begin
                    r_skid <= bus.up_data;
                end
            end

            assign w_skidData = r_skid;
            assign w_upReady  = r_upReady;
        end else begin : g_noSkid
            assign w_skidData = BUBBLE_DATA;
            assign w_upReady  = (r_state == ST_EMPTY) | bus.dn_ready;
        end
    endgenerate

    // Next occupancy and which storage entry loads, from this cycle's push/pop.
    always_comb begin
        w_nextState    = r_state;
        w_loadMainUp   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (flush) begin
            w_nextState = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_nextState  = ST_ONE;
                        w_loadMainUp = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        if (SKID != 0) begin
                            w_nextState = ST_FULL;
                            w_loadSkid  = 1'b1;
                        end
                    end else if (w_pop && !w_push) begin
                        w_nextState = ST_EMPTY;
                    end else if (w_push && w_pop) begin
                        w_loadMainUp = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_nextState    = ST_ONE;
                        w_loadMainSkid = 1'b1;
                    end
                end
                default: begin
                    w_nextState = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy FSM with valid, ready and count all registered from the next state.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= ST_EMPTY;
            r_dnValid   <= 1'b0;
            r_upReady   <= 1'b1;
            r_occupancy <= '0;
        end else begin
            r_state     <= w_nextState;
            r_dnValid   <= (w_nextState != ST_EMPTY);
            r_upReady   <= (w_nextState != ST_FULL);
            r_occupancy <= occ_of_state(w_nextState);
        end
    end

    // Main entry is the head of the queue: refilled from upstream or from the skid entry.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_main <= BUBBLE_DATA;
        end else if (w_loadMainUp) begin
            r_main <= bus.up_data;
        end else if (w_loadMainSkid) begin
            r_main <= w_skidData;
        end
    end

    assign bus.up_ready = w_upReady;
    assign bus.dn_valid = r_dnValid;
    assign bus.dn_data  = r_dnValid ? r_main : BUBBLE_DATA;
    assign occupancy    = r_occupancy;

endmodule
